mem_access_unit: RTL and testbench

Memory-stage load/store unit of the 64-bit RISC-V pipeline, sitting directly upstream of mem_sign_ext.
- Accepts one instruction bundle from EX.
- Issues aligned 64-bit requests to data memory.
- Builds byte enables and shifted store data.
- For loads, right-aligns the addressed bytes into mem_data. Extension/zero-fill is left to mem_sign_ext.
- Non-memory bundles pass through with one register stage.

---
 rtl/mem_access_unit_pkg.sv | 46 ++++
 rtl/mem_access_unit_lane_align.sv | 20 ++
 rtl/mem_access_unit.sv | 120 ++++++++++++
 tb/tb_mem_access_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory-stage load/store unit: pipeline bundle,
// access-unit encodings, FSM states and unit->lane helpers.
package mem_access_unit_pkg;

  localparam logic [1:0] UNIT_B  = 2'd0;
  localparam logic [1:0] UNIT_HW = 2'd1;
  localparam logic [1:0] UNIT_W  = 2'd2;
  localparam logic [1:0] UNIT_DW = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} mem_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_req_unit;
    logic        mem_unsigned;
    logic [63:0] alu_out;
    logic [63:0] rs2_data;
    logic [63:0] mem_data;
    logic        mem_misaligned;
    logic        mem_fault;
  } interconnection_struct;

  function automatic logic [7:0] unit_mask(input logic [1:0] unit);
    case (unit)
      UNIT_B:  return 8'h01;
      UNIT_HW: return 8'h03;
      UNIT_W:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic unit_misaligned(input logic [1:0] unit, input logic [2:0] off);
    case (unit)
      UNIT_B:  return 1'b0;
      UNIT_HW: return off[0];
      UNIT_W:  return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering between a 64-bit aligned memory word and the
// addressed unit: store byte enables/data and load right-alignment.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  unit,
  input  logic [2:0]  off,
  input  logic [63:0] rs2_data,
  input  logic [63:0] rdata,
  output logic [7:0]  be,
  output logic [63:0] wdata,
  output logic [63:0] rdata_shift
);

  // Aligned accesses never carry the mask past lane 7, so no wrap handling.
  assign be          = unit_mask(unit) << off;
  assign wdata       = rs2_data << {off, 3'b000};
  assign rdata_shift = rdata >> {off, 3'b000};

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one bundle in flight, aligned 64-bit
// requests to data memory, load data right-aligned for mem_sign_ext.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  interconnection_struct i_struct,
  output logic                  out_valid,
  input  logic                  out_ready,
  output interconnection_struct o_struct,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  output logic [XLEN/8-1:0]     dmem_be,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [XLEN-1:0]       dmem_rdata
);

  mem_state_t            state, state_nxt;
  interconnection_struct bundle_q;
  logic [CNT_W-1:0]      wait_cnt;

  logic        accept, is_mem, misaligned, capture, timeout;
  logic [2:0]  off_sel;
  logic [7:0]  be_c;
  logic [63:0] wdata_c, rdata_c;

  assign out_valid = (state == RESP);
  assign dmem_req  = (state == REQ);
  assign o_struct  = bundle_q;

  // RESP draining this cycle behaves like IDLE for acceptance.
  assign in_ready   = (state == IDLE) || ((state == RESP) && out_ready);
  assign accept     = in_valid && in_ready;
  assign is_mem     = i_struct.mem_read || i_struct.mem_write;
  assign misaligned = unit_misaligned(i_struct.mem_req_unit, i_struct.alu_out[2:0]);

  assign capture = dmem_rvalid && !dmem_we &&
                   (((state == REQ) && dmem_gnt) || (state == WAIT_R));
  assign timeout = (state == WAIT_R) && !dmem_rvalid &&
                   (wait_cnt == CNT_W'(MAX_WAIT - 1));

  // While a request is outstanding the load shift uses the latched offset.
  assign off_sel = ((state == REQ) || (state == WAIT_R)) ? bundle_q.alu_out[2:0]
                                                         : i_struct.alu_out[2:0];

  mem_lane_align u_lane (
    .unit        (i_struct.mem_req_unit),
    .off         (off_sel),
    .rs2_data    (i_struct.rs2_data),
    .rdata       (dmem_rdata),
    .be          (be_c),
    .wdata       (wdata_c),
    .rdata_shift (rdata_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: begin
        if ((state == RESP) && out_ready) state_nxt = IDLE;
        if (accept) state_nxt = (is_mem && !misaligned) ? REQ : RESP;
      end
      REQ: begin
        if (dmem_gnt) state_nxt = (dmem_we || dmem_rvalid) ? RESP : WAIT_R;
      end
      WAIT_R: begin
        if (dmem_rvalid || timeout) state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_q   <= '0;
      dmem_we    <= 1'b0;
      dmem_be    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wait_cnt   <= '0;
    end else begin
      if (accept) begin
        bundle_q                <= i_struct;
        bundle_q.mem_misaligned <= is_mem && misaligned;
        bundle_q.mem_fault      <= 1'b0;
        if (is_mem && misaligned) bundle_q.mem_data <= '0;
        if (is_mem && !misaligned) begin
          dmem_we    <= i_struct.mem_write;
          dmem_be    <= be_c;
          dmem_addr  <= {i_struct.alu_out[XLEN-1:3], 3'b000};
          dmem_wdata <= wdata_c;
        end
      end
      if (capture) bundle_q.mem_data <= rdata_c;
      if (timeout) begin
        bundle_q.mem_fault <= 1'b1;
        bundle_q.mem_data  <= '0;
      end
      // Held at zero outside WAIT_R so every wait window starts from 0.
      if (state == WAIT_R) wait_cnt <= wait_cnt + 1'b1;
      else                 wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, hand-written corner sequences,
// and randomized bundles checked against a lane/latency reference model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int MAX_WAIT = 16;
  localparam logic [63:0] TAG = 64'h0BAD_F00D_CAFE_0001;

  logic clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0] dmem_be;
  interconnection_struct i_struct, o_struct;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.XLEN(64), .MAX_WAIT(MAX_WAIT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .i_struct(i_struct),
    .out_valid(out_valid), .out_ready(out_ready), .o_struct(o_struct),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  unit;
    logic [63:0] addr;
    logic        rd, wr;
    logic [63:0] rs2, rdata;
    int          gd, rvd, bp;
    int          e_lat, e_reqc;
    logic [63:0] e_addr;
    logic [7:0]  e_be;
    logic [63:0] e_wd;
    logic        e_mis, e_flt;
    logic [63:0] e_data, e_dmask;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_s(input string nm, input interconnection_struct act, input interconnection_struct exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic interconnection_struct mk(input logic [1:0] unit, input logic [63:0] addr,
                                               input logic rd, input logic wr, input logic [63:0] rs2);
    interconnection_struct s;
    s = '0;
    s.pc = 64'h8000_0000 + addr;
    s.instr = 32'h0000_0013 ^ addr[31:0];
    s.rd = addr[8:4];
    s.reg_write = rd;
    s.mem_read = rd;
    s.mem_write = wr;
    s.mem_req_unit = unit;
    s.mem_unsigned = addr[9];
    s.alu_out = addr;
    s.rs2_data = rs2;
    s.mem_data = TAG;
    return s;
  endfunction

  function automatic interconnection_struct rnd_bundle();
    interconnection_struct s;
    s = '0;
    s.pc = {$urandom, $urandom};
    s.instr = $urandom;
    s.rd = 5'($urandom);
    s.reg_write = 1'($urandom);
    s.mem_unsigned = 1'($urandom);
    s.mem_data = {$urandom, $urandom};
    return s;
  endfunction

  // Reference: spec rules as plain arithmetic over bytes and cycle counts.
  function automatic void model(input interconnection_struct b, input logic [63:0] rdata,
      input int gd, input int rvd, output interconnection_struct e, output logic [63:0] dmask,
      output int lat, output int reqc, output logic [63:0] ea, output logic [7:0] ebe,
      output logic [63:0] ewd);
    int nb, off;
    nb = 1 << b.mem_req_unit;
    off = int'(b.alu_out[2:0]);
    e = b; e.mem_misaligned = 1'b0; e.mem_fault = 1'b0;
    dmask = '1; reqc = 0; ea = '0; ebe = '0; ewd = '0;
    if (!(b.mem_read || b.mem_write)) lat = 1;
    else if (off % nb != 0) begin
      e.mem_misaligned = 1'b1; e.mem_data = '0; lat = 1;
    end else begin
      reqc = gd + 1;
      ea = b.alu_out & ~64'h7;
      for (int i = 0; i < nb; i++) ebe[off + i] = 1'b1;
      ewd = b.rs2_data << (8 * off);
      if (b.mem_write) lat = gd + 2;
      else if (rvd <= MAX_WAIT) begin
        lat = gd + 1 + rvd + 1;
        e.mem_data = '0;
        for (int i = 0; i < nb; i++) e.mem_data[8*i +: 8] = rdata[8*(off+i) +: 8];
        dmask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
      end else begin
        e.mem_fault = 1'b1; e.mem_data = '0; lat = gd + 1 + MAX_WAIT + 1;
      end
    end
  endfunction

  task automatic run_and_check(input string nm, input interconnection_struct b, input logic [63:0] rdata,
      input int gd, input int rvd, input int bp, input interconnection_struct e, input logic [63:0] dmask,
      input int elat, input int ereqc, input logic [63:0] ea, input logic [7:0] ebe, input logic [63:0] ewd);
    interconnection_struct o;
    int lat, reqc, g;
    logic [63:0] a, wd;
    logic [7:0] be_o;
    logic we_o, stable;
    lat = -1; reqc = 0; g = -1; a = '0; wd = '0; be_o = '0; we_o = 1'b0; stable = 1'b1; o = '0;
    @(negedge clk);
    in_valid = 1'b1; i_struct = b; out_ready = 1'b0;
    #1 chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0; i_struct = rnd_bundle();
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = {$urandom, $urandom};
      if (out_valid) begin lat = n; o = o_struct; break; end
      if (dmem_req) begin
        reqc++;
        if (reqc == 1) begin a = dmem_addr; be_o = dmem_be; we_o = dmem_we; wd = dmem_wdata; end
        else if (a !== dmem_addr || be_o !== dmem_be || we_o !== dmem_we || wd !== dmem_wdata) stable = 1'b0;
        if (reqc > gd) begin
          dmem_gnt = 1'b1; g = n;
          if (!dmem_we && rvd == 0) begin dmem_rvalid = 1'b1; dmem_rdata = rdata; end
        end
      end else if (g >= 0 && n == g + rvd) begin
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
      end else begin
        dmem_gnt = 1'($urandom_range(0, 1));
      end
    end
    chk({nm, "_latency"}, 64'(lat), 64'(elat));
    chk({nm, "_req_cycles"}, 64'(reqc), 64'(ereqc));
    chk({nm, "_req_stable"}, 64'(stable), 64'd1);
    if (ereqc > 0) begin
      chk({nm, "_addr"}, a, ea);
      chk({nm, "_be"}, 64'(be_o), 64'(ebe));
      chk({nm, "_we"}, 64'(we_o), 64'(b.mem_write));
      chk({nm, "_wdata"}, wd, ewd);
    end
    o.mem_data = o.mem_data & dmask;
    chk_s({nm, "_o_struct"}, o, e);
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      in_valid = 1'b1; i_struct = rnd_bundle();
      dmem_gnt = 1'($urandom); dmem_rvalid = 1'($urandom); dmem_rdata = {$urandom, $urandom};
      #1;
      chk({nm, "_bp_flags"}, {61'd0, in_ready, out_valid, dmem_req}, 64'b010);
      o = o_struct; o.mem_data = o.mem_data & dmask;
      chk_s({nm, "_bp_hold"}, o, e);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1 chk({nm, "_drain_ready"}, {62'd0, in_ready, out_valid}, 64'b11);
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_idle_after"}, {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  function automatic vec_t v(input logic [1:0] unit, input logic [63:0] addr, input logic rd, input logic wr,
      input logic [63:0] rs2, input logic [63:0] rdata, input int gd, input int rvd, input int bp,
      input int e_lat, input int e_reqc, input logic [63:0] e_addr, input logic [7:0] e_be,
      input logic [63:0] e_wd, input logic e_mis, input logic e_flt, input logic [63:0] e_data,
      input logic [63:0] e_dmask);
    vec_t t;
    t.unit = unit; t.addr = addr; t.rd = rd; t.wr = wr; t.rs2 = rs2; t.rdata = rdata;
    t.gd = gd; t.rvd = rvd; t.bp = bp; t.e_lat = e_lat; t.e_reqc = e_reqc; t.e_addr = e_addr;
    t.e_be = e_be; t.e_wd = e_wd; t.e_mis = e_mis; t.e_flt = e_flt; t.e_data = e_data; t.e_dmask = e_dmask;
    return t;
  endfunction

  vec_t vecs[11];

  initial begin
    interconnection_struct b, e, bb;
    logic [63:0] dmask, ea, ewd, addr, m;
    logic [7:0] ebe;
    logic [1:0] unit;
    int lat, reqc, gd, rvd, bp, op;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; i_struct = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

    //        unit     addr          rd wr rs2                     rdata                   gd rvd bp lat rq e_addr        e_be   e_wd                    mis flt data                    dmask
    vecs[0]  = v(UNIT_W,  64'h1004, 1, 0, 64'h0,                   64'h89AB_CDEF_0123_4567, 0, 2,  1, 4,  1, 64'h1000, 8'hF0, 64'h0,                   0, 0, 64'h89AB_CDEF,           64'hFFFF_FFFF);
    vecs[1]  = v(UNIT_B,  64'h2003, 0, 1, 64'h5A,                  64'h0,                   0, 0,  0, 2,  1, 64'h2000, 8'h08, 64'h5A00_0000,          0, 0, TAG,                     '1);
    vecs[2]  = v(UNIT_HW, 64'h3001, 1, 0, 64'h0,                   64'h1234,                0, 0,  0, 1,  0, 64'h0,    8'h00, 64'h0,                  1, 0, 64'h0,                   '1);
    vecs[3]  = v(UNIT_DW, 64'h4000, 1, 0, 64'h0,                   64'hFFFF_0000_FFFF_0000, 1, 99, 2, 19, 2, 64'h4000, 8'hFF, 64'h0,                   0, 1, 64'h0,                   '1);
    vecs[4]  = v(UNIT_W,  64'h4010, 1, 0, 64'h0,                   64'h1111_2222_3333_4444, 0, 16, 0, 18, 1, 64'h4010, 8'h0F, 64'h0,                   0, 0, 64'h3333_4444,           64'hFFFF_FFFF);
    vecs[5]  = v(UNIT_W,  64'h4020, 1, 0, 64'h0,                   64'h5555_6666_7777_8888, 0, 17, 0, 18, 1, 64'h4020, 8'h0F, 64'h0,                   0, 1, 64'h0,                   '1);
    vecs[6]  = v(UNIT_DW, 64'h12345,0, 0, 64'h77,                  64'h0,                   0, 0,  1, 1,  0, 64'h0,    8'h00, 64'h0,                  0, 0, TAG,                     '1);
    vecs[7]  = v(UNIT_DW, 64'h5008, 0, 1, 64'h0123_4567_89AB_CDEF, 64'h0,                   3, 0,  0, 5,  4, 64'h5008, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 0, TAG,                     '1);
    vecs[8]  = v(UNIT_HW, 64'h6006, 1, 0, 64'h0,                   64'hBEEF_0000_0000_0000, 2, 0,  0, 4,  3, 64'h6000, 8'hC0, 64'h0,                   0, 0, 64'hBEEF,                64'hFFFF);
    vecs[9]  = v(UNIT_W,  64'h7002, 0, 1, 64'h1,                   64'h0,                   0, 0,  0, 1,  0, 64'h0,    8'h00, 64'h0,                  1, 0, 64'h0,                   '1);
    vecs[10] = v(UNIT_HW, 64'h700A, 0, 1, 64'hAAAA_BBBB_CCCC_1234, 64'h0,                   0, 0,  0, 2,  1, 64'h7008, 8'h0C, 64'hBBBB_CCCC_1234_0000, 0, 0, TAG,                     '1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", {59'd0, out_valid, dmem_req, dmem_we, in_ready, 1'b0}, 64'b00010);
    chk("reset_be", 64'(dmem_be), 64'd0);
    chk("reset_addr", dmem_addr, 64'd0);
    chk("reset_wdata", dmem_wdata, 64'd0);
    chk_s("reset_o_struct", o_struct, '0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      b = mk(vecs[i].unit, vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].rs2);
      e = b;
      e.mem_misaligned = vecs[i].e_mis;
      e.mem_fault = vecs[i].e_flt;
      e.mem_data = vecs[i].e_data;
      run_and_check($sformatf("vec%0d", i), b, vecs[i].rdata, vecs[i].gd, vecs[i].rvd, vecs[i].bp,
                    e, vecs[i].e_dmask, vecs[i].e_lat, vecs[i].e_reqc, vecs[i].e_addr, vecs[i].e_be, vecs[i].e_wd);
    end

    // Backpressure then back-to-back acceptance in the draining cycle.
    b  = mk(UNIT_B, 64'hA0, 0, 0, 64'h1);
    bb = mk(UNIT_W, 64'hB0, 0, 0, 64'h2);
    @(negedge clk);
    in_valid = 1'b1; i_struct = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_first_valid", 64'(out_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; i_struct = bb;
      #1;
      chk("b2b_hold_ready", 64'(in_ready), 64'd0);
      chk_s("b2b_hold_struct", o_struct, b);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; i_struct = bb;
    #1 chk("b2b_accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("b2b_second_valid", 64'(out_valid), 64'd1);
    chk_s("b2b_second_struct", o_struct, bb);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Reset while waiting for load data; the late rvalid must be dropped.
    @(negedge clk);
    in_valid = 1'b1; i_struct = mk(UNIT_W, 64'h8000, 1, 0, 64'h0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_req", 64'(dmem_req), 64'd1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("rst_mid_wait", {62'd0, dmem_req, out_valid}, 64'b00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_mid_idle", {61'd0, out_valid, dmem_req, in_ready}, 64'b001);
      @(negedge clk);
    end
    chk("rst_mid_be", 64'(dmem_be), 64'd0);

    for (int t = 0; t < 150; t++) begin
      unit = 2'($urandom_range(0, 3));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) begin
        m = (64'd1 << unit) - 64'd1;
        addr = addr & ~m;
      end
      op = $urandom_range(0, 4);
      b = rnd_bundle();
      b.mem_read = (op == 1 || op == 2);
      b.mem_write = (op >= 3);
      b.mem_req_unit = unit;
      b.alu_out = addr;
      b.rs2_data = {$urandom, $urandom};
      gd = $urandom_range(0, 3);
      rvd = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 5) : $urandom_range(6, 20);
      bp = $urandom_range(0, 3);
      m = {$urandom, $urandom};
      model(b, m, gd, rvd, e, dmask, lat, reqc, ea, ebe, ewd);
      run_and_check($sformatf("rnd%0d", t), b, m, gd, rvd, bp, e, dmask, lat, reqc, ea, ebe, ewd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
